// File: rtl/mmm_pkg.sv
// Shared constants and FSM state type for the instruction-cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmm_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;

    // Controller states: idle, tag compare, refill request, refill beats.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        MEM_REQ = 2'd2,
        REFILL  = 2'd3
    } icache_state_t;

endpackage

// File: rtl/icache_ctrl_refill_counter.sv
// Beat index for a line refill: counts accepted beats, wraps at line end.
// Latency: index updates on the clock edge after each enabled beat.
// Backpressure: none; counts only when enabled, clear has priority.
module refill_counter #(
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             last,
    output logic             wrap
);

    // last marks the final word slot; wrap is that slot actually being written
    assign last = (cnt == IDX_W'(LINE_WORDS - 1));
    assign wrap = en && last;

    // Power-of-two line size lets the increment wrap naturally to zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + IDX_W'(1);
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: lookup, line refill from memory, replay on miss.
// Latency: hit returns line 1 cycle after acceptance; miss adds grant wait + LINE_WORDS beats + replay.
// Backpressure: read_ready_o only in IDLE without flush; memory side holds mem_req_o until mem_gnt_i.
module icache_ctrl #(
    parameter int ADDR_W     = mmm_pkg::ADDR_W,
    parameter int WORD_W     = mmm_pkg::WORD_W,
    parameter int LINE_WORDS = mmm_pkg::LINE_WORDS
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             flush_i,
    input  logic                             read_req_i,
    input  logic [ADDR_W-1:0]                read_addr_i,
    output logic                             read_ready_o,
    output logic                             read_done_o,
    output logic [LINE_WORDS*WORD_W-1:0]     line_o,
    output logic [ADDR_W-1:0]                lookup_addr_o,
    input  logic                             hit_i,
    input  logic [LINE_WORDS*WORD_W-1:0]     array_line_i,
    output logic                             mem_req_o,
    output logic [ADDR_W-1:0]                mem_addr_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [WORD_W-1:0]                mem_rdata_i,
    output logic                             data_we_o,
    output logic [$clog2(LINE_WORDS)-1:0]    data_widx_o,
    output logic [WORD_W-1:0]                data_wdata_o,
    output logic                             tag_we_o
);

    import mmm_pkg::*;

    localparam int IDX_W = $clog2(LINE_WORDS);
    // Byte-offset bits within one line; zeroed for the refill address
    localparam int OFF_W = $clog2(LINE_WORDS * WORD_W / 8);

    icache_state_t     state_q;
    icache_state_t     state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              abort_q;

    logic              beat_clr;
    logic              beat_en;
    logic [IDX_W-1:0]  beat_cnt;
    logic              beat_last;
    logic              beat_wrap;
    logic [ADDR_W-1:0] line_addr;

    assign line_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    // Counter restarts on grant so beat 0 of every refill lands in word 0
    assign beat_clr  = (state_q == MEM_REQ) && mem_gnt_i;
    assign beat_en   = (state_q == REFILL) && mem_rvalid_i;

    refill_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill_counter (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (beat_clr),
        .en    (beat_en),
        .cnt   (beat_cnt),
        .last  (beat_last),
        .wrap  (beat_wrap)
    );

    // Next-state selection; a flush only cuts short IDLE/LOOKUP, never a refill in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && read_req_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (flush_i || hit_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (mem_gnt_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // Aborted refills still finish the line but skip the replay
                if (beat_wrap) begin
                    state_d = (abort_q || flush_i) ? IDLE : LOOKUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; everything is forced to zero while reset is asserted
    always_comb begin
        read_ready_o  = 1'b0;
        read_done_o   = 1'b0;
        line_o        = '0;
        lookup_addr_o = '0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        data_we_o     = 1'b0;
        data_widx_o   = '0;
        data_wdata_o  = '0;
        tag_we_o      = 1'b0;
        if (rst_n_i) begin
            // In IDLE the arrays see the incoming address so the tag read overlaps acceptance
            lookup_addr_o = (state_q == IDLE) ? read_addr_i : addr_q;
            case (state_q)
                IDLE: begin
                    read_ready_o = !flush_i;
                end
                LOOKUP: begin
                    if (hit_i && !flush_i) begin
                        read_done_o = 1'b1;
                        line_o      = array_line_i;
                    end
                end
                MEM_REQ: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = line_addr;
                end
                REFILL: begin
                    if (mem_rvalid_i) begin
                        data_we_o    = 1'b1;
                        data_widx_o  = beat_cnt;
                        data_wdata_o = mem_rdata_i;
                        tag_we_o     = beat_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, captured request address and pending-abort flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && read_req_i && !flush_i) begin
                addr_q <= read_addr_i;
            end
            if (state_d == IDLE) begin
                abort_q <= 1'b0;
            end else if (((state_q == MEM_REQ) || (state_q == REFILL)) && flush_i) begin
                abort_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameters (one per line: name, default, meaning); all SHALL be taken from the shared package constants:
  ADDR_W, 32, byte address width
  WORD_W, 32, memory beat / instruction word width
  LINE_WORDS, 4, words per cache line (power of two, >=2)
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk_i  in  1  clock; all state updates on rising edge
  rst_n_i  in  1  reset, synchronous, active-low
  flush_i  in  1  abort current fetch read
  read_req_i  in  1  fetch read request
  read_addr_i  in  ADDR_W  fetch address, valid with read_req_i
  read_ready_o  out  1  controller can accept read_req_i
  read_done_o  out  1  one-cycle pulse: line_o valid
  line_o  out  LINE_WORDS*WORD_W  line returned to fetch
  lookup_addr_o  out  ADDR_W  address presented to tag/data arrays
  hit_i  in  1  tag match for lookup_addr_o, same cycle
  array_line_i  in  LINE_WORDS*WORD_W  data array line for lookup_addr_o, same cycle
  mem_req_o  out  1  refill request to memory
  mem_addr_o  out  ADDR_W  line-aligned refill address
  mem_gnt_i  in  1  memory accepted mem_req_o
  mem_rvalid_i  in  1  refill beat valid
  mem_rdata_i  in  WORD_W  refill beat data
  data_we_o  out  1  write one word into data array
  data_widx_o  out  $clog2(LINE_WORDS)  word index within line
  data_wdata_o  out  WORD_W  word to write
  tag_we_o  out  1  write tag+valid for lookup_addr_o

Function
REQ-003 FSM states SHALL be IDLE, LOOKUP, MEM_REQ, REFILL.
REQ-004 read_ready_o SHALL be 1 only in IDLE with flush_i=0; read_req_i SHALL be ignored in any other state.
REQ-005 IDLE: read_req_i=1 and flush_i=0 SHALL register read_addr_i into addr_q and go to LOOKUP.
REQ-006 lookup_addr_o SHALL equal addr_q in every state except IDLE, where it SHALL equal read_addr_i.
REQ-007 LOOKUP with hit_i=1: read_done_o=1 and line_o=array_line_i in that same cycle, next state IDLE (hit latency 1 cycle after acceptance).
REQ-008 LOOKUP with hit_i=0: next state MEM_REQ; read_done_o=0.
REQ-009 MEM_REQ: mem_req_o=1 and mem_addr_o=addr_q with low $clog2(LINE_WORDS*WORD_W/8) bits zeroed, held stable until mem_gnt_i=1; on grant go to REFILL, clear beat counter.
REQ-010 REFILL: each cycle with mem_rvalid_i=1 SHALL assert data_we_o with data_widx_o=beat counter, data_wdata_o=mem_rdata_i, and increment counter (modulo LINE_WORDS).
REQ-011 On the beat where counter=LINE_WORDS-1, tag_we_o SHALL pulse for one cycle alongside data_we_o; next state LOOKUP (replay, guaranteed hit) unless abort_q=1, then IDLE.
REQ-012 mem_rvalid_i outside REFILL SHALL be ignored; no data_we_o.
REQ-013 flush_i in IDLE or LOOKUP: next state IDLE, read_done_o=0 that cycle; flush with read_req_i in IDLE: flush wins, request not accepted.
REQ-014 flush_i in MEM_REQ or REFILL: set abort_q; request and refill SHALL complete fully (incl. tag_we_o), then IDLE without read_done_o; abort_q cleared on entering IDLE.
REQ-015 read_done_o SHALL never assert outside LOOKUP and at most once per accepted request.

Reset
REQ-016 rst_n_i=0 at a clock edge SHALL force IDLE, clear addr_q, beat counter and abort_q, from any state including mid-refill.
REQ-017 While in reset all outputs SHALL be 0 (line_o, mem_addr_o, lookup_addr_o included); read_ready_o becomes 1 the first cycle after release.

Structure
REQ-018 icache_state_t and ADDR_W, WORD_W, LINE_WORDS SHALL live in mmm_pkg.
REQ-019 The beat counter SHALL be a sub-module refill_counter (clear, enable, wrap, last flag).
REQ-020 Two always_comb blocks (next state, outputs) plus one always_ff; no latches.

Verification
REQ-021 Hit: req addr 0x1004, hit_i=1 -> read_done_o pulse one cycle later, line_o=array_line_i, back to IDLE.
REQ-022 Miss: addr 0x2008, hit_i=0, gnt after 3 cycles, 4 beats -> mem_addr_o=0x2000, data_widx_o 0..3, tag_we_o on beat 3, replay hit, read_done_o once.
REQ-023 Gapped beats: rvalid pattern 1,0,1,0,1,1 -> exactly 4 writes, indices 0..3 in order.
REQ-024 Flush in REFILL after beat 1 -> beats 2,3 still written, tag_we_o pulses, no read_done_o, IDLE.
REQ-025 flush_i with read_req_i in IDLE -> not accepted, read_ready_o=0 that cycle, state IDLE.
REQ-026 rst_n_i=0 during MEM_REQ -> next cycle mem_req_o=0, all outputs 0, IDLE after release.
